// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin sequencer that shares one WIDTH-bit ripple adder between two
// requesters. An add takes one adder pass (EXEC). A subtract takes two passes:
// NEG forms the two's complement of B, then EXEC adds it to A. The block adds
// the carry/borrow flag that the bare adder does not provide.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   req0_i, req1_i   level requests; operands/op held stable until done
//   op0_i,  op1_i    0 = add (A+B), 1 = subtract (A-B)
//   a0_i, b0_i       requester 0 operands
//   a1_i, b1_i       requester 1 operands
//   gnt0_o, gnt1_o   one-cycle pulse, first cycle after a job is accepted
//   done0_o, done1_o one-cycle pulse, result_o/flag_o valid for that requester
//   result_o         registered result, held until the next done
//   flag_o           add: carry-out, sub: borrow (A < B unsigned)
//   busy_o           high in every state except IDLE
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             op0_i,
  input  logic             op1_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEG,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // index of the most recent winner
  logic             idx_q, idx_d;        // requester currently being served
  logic             op_q, op_d;
  logic             borrow_q, borrow_d;  // borrow captured at grant time
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;            // holds -B after NEG for a subtract
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             win;

  // Shared adder: operand mux plus a single ripple-carry chain.
  logic [WIDTH-1:0] add_a, add_b, sum;

  assign add_a = (state_q == S_NEG) ? ~b_q : a_q;
  assign add_b = (state_q == S_NEG) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;

  always_comb begin : ripple_adder
    logic c;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = add_a[i] ^ add_b[i] ^ c;
      c      = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
    end
  end

  // Tie goes to the requester that did not win last; a lone request wins.
  assign win = req1_i & (~req0_i | ~last_q);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    op_d     = op_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flag_d   = flag_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          idx_d    = win;
          last_d   = win;
          op_d     = win ? op1_i : op0_i;
          a_d      = win ? a1_i  : a0_i;
          b_d      = win ? b1_i  : b0_i;
          borrow_d = win ? (op1_i && (a1_i < b1_i)) : (op0_i && (a0_i < b0_i));
          gnt0_d   = ~win;
          gnt1_d   = win;
          state_d  = (win ? op1_i : op0_i) ? S_NEG : S_EXEC;
        end
      end
      S_NEG: begin
        b_d     = sum;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = sum;
        // Unsigned wrap of A+B means a carry out of the top bit.
        flag_d   = op_q ? borrow_q : (sum < a_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand latches are reset along with control state so an aborted
  // job never leaves stale data that could be mistaken for a live one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      idx_q    <= 1'b0;
      op_q     <= 1'b0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
    end
  end

  assign gnt0_o   = gnt0_q;
  assign gnt1_o   = gnt1_q;
  assign done0_o  = (state_q == S_DONE) && !idx_q;
  assign done1_o  = (state_q == S_DONE) &&  idx_q;
  assign result_o = result_q;
  assign flag_o   = flag_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule
